fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch front end: owns the program counter and drives the instruction-memory address.
- Captures the returned word into the IF/ID pipeline register, with valid, stall, redirect (branch/jump) and halt control.
- Sits directly upstream of decode.
- Keeps a free-running fetched-instruction counter for performance reporting.

Parameters:
- WIDTH, 32, datapath width of PC, instruction and counter.
- RESET_PC, 0, PC value loaded on reset.
- INC, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; rst=0 resets all state immediately.
- stall  input  1  decode cannot accept; hold PC and IF/ID.
- redirect  input  1  taken branch/jump from later stage.
- redirect_pc  input  WIDTH  redirect target; two least-significant bits are ignored (forced 0).
- halt_req  input  1  stop fetching until reset.
- imem_addr  output  WIDTH  instruction-memory address, combinational copy of PC.
- imem_rdata  input  WIDTH  instruction word, valid in the same cycle as imem_addr.
- ifid_pc  output  WIDTH  PC of the instruction in IF/ID.
- ifid_pc_next  output  WIDTH  ifid_pc + INC (link value).
- ifid_instr  output  WIDTH  captured instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  FSM is in HALTED.
- fetch_count  output  WIDTH  number of valid IF/ID loads since reset.

Behaviour:
- Reset (rst=0, async):
  - PC=RESET_PC, state=BOOT.
  - ifid_pc, ifid_pc_next and ifid_instr = 0.
  - ifid_valid=0, halted=0, fetch_count=0.
- FSM states: BOOT, RUN, HALTED.
- BOOT:
  - Lasts exactly one cycle after reset release.
  - PC holds, ifid_valid stays 0, all inputs ignored.
  - Next state is RUN unconditionally.
- RUN: at each posedge, evaluate in strict priority:
  - 1. redirect=1: PC <= redirect_pc with its two LSBs cleared; ifid_valid <= 0 (squash); IF/ID data fields hold. Applies even when stall=1.
  - 2. halt_req=1: state <= HALTED; PC holds; ifid_valid <= 0.
  - 3. stall=1: PC, all IF/ID fields and fetch_count hold.
  - 4. otherwise: PC <= PC+INC; ifid_pc <= PC; ifid_pc_next <= PC+INC; ifid_instr <= imem_rdata; ifid_valid <= 1; fetch_count <= fetch_count+1.
- Fetch latency: instruction at address A appears in IF/ID one edge after imem_addr=A with no stall.
  - First valid instruction after reset appears at the second posedge following reset release.
- HALTED:
  - halted=1; PC and IF/ID data hold; ifid_valid=0.
  - redirect, stall and halt_req are ignored.
  - Only reset exits HALTED.
- Arithmetic:
  - PC+INC and fetch_count+1 are unsigned modulo 2^WIDTH; wrap silently (0xFFFFFFFC+4 = 0).
  - No overflow flag.
- imem_addr always equals PC, including in BOOT and HALTED.
- Reset asserted mid-operation: all state returns to reset values asynchronously, regardless of FSM state or pending redirect.

Decomposition:
- Shared package:
  - FSM state encoding (BOOT=2'b00, RUN=2'b01, HALTED=2'b10).
  - Default RESET_PC and INC constants.
  - IF/ID field widths, shared with the decode stage.
- One natural sub-module, ifid_reg: the IF/ID pipeline register holding {pc, pc_next, instr, valid} with load, squash and async active-low reset.
  - Built from the team's standard pipe register.
- PC and fetch_count incrementers use the team's n-bit adder.

Test Plan:
- Reset then release, imem returns 0x11111111 @0, 0x22222222 @4, no stall:
  - ifid_valid=0 through BOOT.
  - Second edge: ifid_pc=0, ifid_instr=0x11111111, fetch_count=1.
  - Third edge: ifid_pc=4, ifid_instr=0x22222222, fetch_count=2.
- Stall held 3 cycles while PC=8:
  - imem_addr stays 8; IF/ID and fetch_count unchanged.
  - After release, next edge loads the instruction from 8.
- redirect=1 with redirect_pc=0x00000103 while stall=1:
  - Next edge: imem_addr=0x100, ifid_valid=0.
  - Following edge: ifid_pc=0x100, ifid_valid=1.
- halt_req=1 in RUN:
  - Next edge: halted=1, ifid_valid=0.
  - Later redirect to 0x40 is ignored; PC unchanged.
  - Async rst=0 clears halted to 0 and PC to RESET_PC before the next clock edge.
- Redirect to 0xFFFFFFFC, no stall: IF/ID gets pc=0xFFFFFFFC, pc_next=0, and PC wraps to 0.
- Async reset asserted mid-cycle during a redirect: outputs return to reset values without waiting for an edge; BOOT repeats on release.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: definitions shared by the instruction-fetch stage and the
// decode stage that consumes its IF/ID register.
//   - fetch_state_e : fetch FSM state encoding
//   - DEFAULT_*     : default datapath width, reset PC and sequential increment
//   - IFID_*_W      : IF/ID field widths as seen by decode
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_e;

    localparam int unsigned DEFAULT_WIDTH    = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_INC      = 32'h0000_0004;

    localparam int unsigned IFID_PC_W      = DEFAULT_WIDTH;
    localparam int unsigned IFID_PC_NEXT_W = DEFAULT_WIDTH;
    localparam int unsigned IFID_INSTR_W   = DEFAULT_WIDTH;
    localparam int unsigned IFID_VALID_W   = 1;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register {pc, pc_next, instr, valid}.
//   clk, rst (async, active-low)
//   load    : capture pc_in/pc_next_in/instr_in and set valid
//   squash  : clear valid, data fields hold (wins over load)
//   pc, pc_next, instr, valid : registered IF/ID contents
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             squash,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] pc_next_in,
    input  logic [WIDTH-1:0] instr_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] instr,
    output logic             valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= '0;
            pc_next <= '0;
            instr   <= '0;
            valid   <= 1'b0;
        end else if (squash) begin
            valid <= 1'b0;
        end else if (load) begin
            pc      <= pc_in;
            pc_next <= pc_next_in;
            instr   <= instr_in;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Owns the PC, drives the
// instruction-memory address and loads the IF/ID register for decode.
//   clk, rst (async, active-low)
//   stall                  : hold PC and IF/ID
//   redirect, redirect_pc  : taken branch/jump; target low two bits dropped
//   halt_req               : stop fetching until reset
//   imem_addr / imem_rdata : combinational instruction-memory interface
//   ifid_*                 : IF/ID register contents
//   halted                 : FSM is in HALTED
//   fetch_count            : number of valid IF/ID loads since reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter logic [WIDTH-1:0] INC      = WIDTH'(DEFAULT_INC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] ifid_pc,
    output logic [WIDTH-1:0] ifid_pc_next,
    output logic [WIDTH-1:0] ifid_instr,
    output logic             ifid_valid,
    output logic             halted,
    output logic [WIDTH-1:0] fetch_count
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus;
    logic             load, squash;

    // Sequential increment wraps modulo 2^WIDTH.
    assign pc_plus = pc_q + INC;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        squash  = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Redirect outranks halt and stall; it squashes IF/ID.
                if (redirect) begin
                    pc_d   = redirect_pc & ~WIDTH'(3);
                    squash = 1'b1;
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                    squash  = 1'b1;
                end else if (!stall) begin
                    pc_d = pc_plus;
                    load = 1'b1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
        end else if (load) begin
            fetch_count <= fetch_count + WIDTH'(1);
        end
    end

    ifid_reg #(
        .WIDTH(WIDTH)
    ) u_ifid_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .squash     (squash),
        .pc_in      (pc_q),
        .pc_next_in (pc_plus),
        .instr_in   (imem_rdata),
        .pc         (ifid_pc),
        .pc_next    (ifid_pc_next),
        .instr      (ifid_instr),
        .valid      (ifid_valid)
    );

    assign imem_addr = pc_q;
    assign halted    = (state_q == ST_HALTED);

endmodule
